// File: rtl/addsub_pkg.sv
// Shared definitions for the chunk-serial add/subtract unit.
// FSM state encoding and a ceil-log2 helper for index sizing.
package addsub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational ripple of full-adder cells, CHUNK bits wide.
// Also exposes the carry into the top bit for overflow detection.
module chunk_adder #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             cin_msb_o
);

    logic [CHUNK:0] c;

    assign c[0] = cin_i;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o    = c[CHUNK];
    assign cin_msb_o = c[CHUNK-1];

endmodule

// File: rtl/multicycle_addsub.sv
// Chunk-serial add/subtract with C/V/Z/N flags and valid/ready handshakes.
// Adds CHUNK bits per cycle, LSB chunk first, over WIDTH/CHUNK cycles.
module multicycle_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0)
    begin : g_param_err
        $error("multicycle_addsub: illegal WIDTH/CHUNK combination");
    end

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  sum_q;
    logic [WIDTH-1:0]  sum_full;
    logic [IDXW-1:0]   idx_q;
    logic              carry_q;
    logic              cout_q;
    logic              ovf_q;
    logic              zero_q;
    logic              neg_q;
    logic              accept;
    logic              last;
    logic [31:0]       base;
    logic [CHUNK-1:0]  ch_a;
    logic [CHUNK-1:0]  ch_b;
    logic [CHUNK-1:0]  ch_sum;
    logic              ch_cout;
    logic              ch_cin_msb;

    assign accept = in_valid && (state_q == S_IDLE);
    assign last   = (idx_q == LAST_IDX);
    assign base   = 32'(idx_q) * 32'(CHUNK);
    assign ch_a   = a_q[base +: CHUNK];
    assign ch_b   = b_q[base +: CHUNK];

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_i       (ch_a),
        .b_i       (ch_b),
        .cin_i     (carry_q),
        .sum_o     (ch_sum),
        .cout_o    (ch_cout),
        .cin_msb_o (ch_cin_msb)
    );

    // Result as it will look once the current chunk is written back.
    always_comb begin
        sum_full = sum_q;
        sum_full[base +: CHUNK] = ch_sum;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> RUN -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the registered state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand latch, per-chunk accumulate and flag capture on the last chunk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= a;
                b_q     <= sub ? ~b : b;
                carry_q <= cin;
                idx_q   <= '0;
            end
            if (state_q == S_RUN) begin
                sum_q   <= sum_full;
                carry_q <= ch_cout;
                if (last) begin
                    cout_q <= ch_cout;
                    ovf_q  <= ch_cin_msb ^ ch_cout;
                    zero_q <= (sum_full == '0);
                    neg_q  <= sum_full[WIDTH-1];
                end else begin
                    idx_q <= idx_q + IDXW'(1);
                end
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;
    assign neg  = neg_q;

endmodule

// File: tb/tb_multicycle_addsub.sv
// Bench for multicycle_addsub: directed table, corner sequences,
// and a random sweep over CHUNK = 1, 4, 8 against a reference model.
module tb_multicycle_addsub;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid_s [4];
    logic       in_ready_s [4];
    logic [7:0] a_s        [4];
    logic [7:0] b_s        [4];
    logic       cin_s      [4];
    logic       sub_s      [4];
    logic       out_valid_s[4];
    logic       out_ready_s[4];
    logic [7:0] sum_s      [4];
    logic       cout_s     [4];
    logic       ovf_s      [4];
    logic       zero_s     [4];
    logic       neg_s      [4];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Instance 0: CHUNK=2 (directed); 1..3: CHUNK=1,4,8 (sweep).
    for (genvar g = 0; g < 4; g++) begin : g_dut
        multicycle_addsub #(
            .WIDTH (8),
            .CHUNK ((g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 8)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_s[g]),
            .in_ready  (in_ready_s[g]),
            .a         (a_s[g]),
            .b         (b_s[g]),
            .cin       (cin_s[g]),
            .sub       (sub_s[g]),
            .out_valid (out_valid_s[g]),
            .out_ready (out_ready_s[g]),
            .sum       (sum_s[g]),
            .cout      (cout_s[g]),
            .ovf       (ovf_s[g]),
            .zero      (zero_s[g]),
            .neg       (neg_s[g])
        );
    end

    typedef struct {
        string      nm;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic [3:0] flags;
    } vec_t;

    vec_t vecs[8];

    function automatic int nch(input int k);
        case (k)
            0:       return 4;
            1:       return 8;
            2:       return 2;
            default: return 1;
        endcase
    endfunction

    // Flags packed as {C, V, Z, N}.
    function automatic logic [11:0] model(input logic [7:0] av,
                                          input logic [7:0] bv,
                                          input logic ci,
                                          input logic sb);
        logic [7:0] bb;
        logic [8:0] r;
        logic       v;
        bb = sb ? ~bv : bv;
        r  = {1'b0, av} + {1'b0, bb} + {8'd0, ci};
        v  = (av[7] == bb[7]) && (r[7] != av[7]);
        return {r[7:0], r[8], v, (r[7:0] == 8'd0), r[7]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic start(input int k, input logic [7:0] av,
                         input logic [7:0] bv, input logic ci,
                         input logic sb);
        a_s[k]        = av;
        b_s[k]        = bv;
        cin_s[k]      = ci;
        sub_s[k]      = sb;
        in_valid_s[k] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_s[k] = 1'b0;
        a_s[k]        = 8'($urandom);
        b_s[k]        = 8'($urandom);
        cin_s[k]      = ~ci;
        sub_s[k]      = ~sb;
    endtask

    // Latency counts edges from the accept edge (inclusive) to out_valid.
    task automatic wait_done(input int k, output int lat);
        lat = 1;
        while (!out_valid_s[k] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic accept_out(input int k);
        out_ready_s[k] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_s[k] = 1'b0;
    endtask

    task automatic run_check(input int k, input string nm,
                             input logic [7:0] av, input logic [7:0] bv,
                             input logic ci, input logic sb,
                             input logic [7:0] es, input logic [3:0] ef);
        int lat;
        start(k, av, bv, ci, sb);
        wait_done(k, lat);
        chk({nm, ".lat"}, lat, nch(k) + 1);
        chk({nm, ".sum"}, sum_s[k], es);
        chk({nm, ".flags"},
            {cout_s[k], ovf_s[k], zero_s[k], neg_s[k]}, ef);
        accept_out(k);
        chk({nm, ".ovalid_clr"}, out_valid_s[k], 1'b0);
    endtask

    initial begin
        logic [11:0] m;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic        rc;
        logic        rs;

        vecs[0] = '{"add7f01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 4'b0101};
        vecs[1] = '{"addff01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 4'b1010};
        vecs[2] = '{"sub0507", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 4'b0001};
        vecs[3] = '{"sub8001", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 4'b1100};
        vecs[4] = '{"add1234c", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 4'b0000};
        vecs[5] = '{"sub1010", 8'h10, 8'h10, 1'b1, 1'b1, 8'h00, 4'b1010};
        vecs[6] = '{"add8080", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 4'b1110};
        vecs[7] = '{"sub0001b", 8'h00, 8'h01, 1'b0, 1'b1, 8'hFE, 4'b0001};

        for (int k = 0; k < 4; k++) begin
            in_valid_s[k]  = 1'b0;
            out_ready_s[k] = 1'b0;
            a_s[k]         = 8'h00;
            b_s[k]         = 8'h00;
            cin_s[k]       = 1'b0;
            sub_s[k]       = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("rst.in_ready", in_ready_s[0], 1'b1);
        chk("rst.out_valid", out_valid_s[0], 1'b0);
        chk("rst.sum", sum_s[0], 8'h00);
        chk("rst.flags", {cout_s[0], ovf_s[0], zero_s[0], neg_s[0]}, 4'b0);

        for (int i = 0; i < 8; i++) begin
            run_check(0, vecs[i].nm, vecs[i].a, vecs[i].b, vecs[i].cin,
                      vecs[i].sub, vecs[i].sum, vecs[i].flags);
        end

        // out_ready while idle is ignored.
        out_ready_s[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_s[0] = 1'b0;
        chk("idle_ordy.in_ready", in_ready_s[0], 1'b1);

        // Backpressure: result held, new operands refused.
        begin
            int lat;
            start(0, 8'h12, 8'h34, 1'b1, 1'b0);
            wait_done(0, lat);
            chk("bp.lat", lat, 5);
            in_valid_s[0] = 1'b1;
            a_s[0]        = 8'hFF;
            b_s[0]        = 8'hFF;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk);
                #1;
                chk("bp.out_valid", out_valid_s[0], 1'b1);
                chk("bp.in_ready", in_ready_s[0], 1'b0);
                chk("bp.sum", sum_s[0], 8'h47);
                chk("bp.flags",
                    {cout_s[0], ovf_s[0], zero_s[0], neg_s[0]}, 4'b0000);
            end
            in_valid_s[0] = 1'b0;
            accept_out(0);
            chk("bp.release.ovalid", out_valid_s[0], 1'b0);
            chk("bp.release.irdy", in_ready_s[0], 1'b1);
        end

        // Reset after two chunks aborts the op.
        start(0, 8'h7F, 8'h01, 1'b0, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rstrun.out_valid", out_valid_s[0], 1'b0);
        chk("rstrun.in_ready", in_ready_s[0], 1'b1);
        chk("rstrun.sum", sum_s[0], 8'h00);
        repeat (6) begin
            @(posedge clk);
            #1;
            chk("rstrun.no_result", out_valid_s[0], 1'b0);
        end
        run_check(0, "post_rst", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 4'b1100);

        // Random sweep on CHUNK = 1, 4, 8.
        for (int k = 1; k < 4; k++) begin
            run_check(k, "dir_sub0507", 8'h05, 8'h07, 1'b1, 1'b1,
                      8'hFE, 4'b0001);
            for (int n = 0; n < 1000; n++) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                rc = 1'($urandom);
                rs = 1'($urandom);
                m  = model(ra, rb, rc, rs);
                run_check(k, $sformatf("rnd_c%0d_%0d", nch(k), n),
                          ra, rb, rc, rs, m[11:4], m[3:0]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
